stereo_limiter: RTL and testbench
=================================

Name: stereo_limiter

Overview:
- Linked-gain stereo peak limiter between the routing matrix outputs and the I2S transmitter.
- Once per DACLRC frame it captures the left/right samples and computes a gain that keeps the larger peak at or below a CPU-set threshold.
- It smooths that gain with separate attack and release shifts, applies it to both channels and presents registered outputs for i2s_tx.
- Runs entirely on the OSC clock (49.152 MHz, 1024 clk per 48 kHz frame).

Parameters:
- BITSIZE, 16, sample width; in/out are signed two's complement.
- SHIFTBITS, 4, width of attack_shift / release_shift.

Ports:
- clk  in  1  system clock (OSC).
- resetn  in  1  synchronous, active-low reset.
- enable  in  1  1 = limit; 0 = bypass.
- lrclk  in  1  DACLRC from the codec, asynchronous; synchronised internally.
- in_l  in  BITSIZE  signed left sample.
- in_r  in  BITSIZE  signed right sample.
- threshold  in  BITSIZE  unsigned limit level; valid range 0..2^(BITSIZE-1).
- attack_shift  in  SHIFTBITS  gain-decrease smoothing shift; 0 = instant.
- release_shift  in  SHIFTBITS  gain-increase smoothing shift; 0 = instant.
- out_l  out  BITSIZE  signed limited left sample.
- out_r  out  BITSIZE  signed limited right sample.
- gain  out  BITSIZE+1  current gain; unity U = 2^BITSIZE.
- limiting  out  1  high while gain < U.
- out_valid  out  1  one-clk pulse when out_l/out_r update.

Behaviour:
- Reset, when resetn is low at a clk edge:
  - out_l = out_r = 0, out_valid = 0, gain = U, limiting = 0, FSM = IDLE.
  - Both lrclk synchroniser flops and the edge-detect flop are set to 1, so releasing reset with lrclk high produces no spurious edge.
- Frame start: a rising edge of the synchronised lrclk (2 flops plus an edge flop) is accepted only in IDLE. Edges seen in any other state are ignored.
- FSM, one state per clk unless noted:
  - IDLE -> CAPT on edge.
  - CAPT: latch in_l and in_r. Form abs values in BITSIZE-bit unsigned, so |-2^(BITSIZE-1)| = 2^(BITSIZE-1) with no overflow.
  - PEAK: peak = max(abs_l, abs_r).
  - DIV: exactly BITSIZE+1 cycles of a restoring divider.
    - If enable = 1 and peak > threshold: target = floor(threshold * 2^BITSIZE / peak). This is always < U.
    - Otherwise target = U; the divider still runs its full cycle count, so latency stays fixed.
  - SMOOTH: with d = |gain - target|.
    - target < gain: step = d >> attack_shift, then gain -= step.
    - target > gain: step = d >> release_shift, then gain += step.
    - If d != 0 and the shifted step is 0, step = 1.
    - enable = 0 forces gain = U.
  - APPLY: p = sample * gain, as a signed (2*BITSIZE+2)-bit product. Result = p >>> BITSIZE (floor), clamped to [-2^(BITSIZE-1), 2^(BITSIZE-1)-1].
  - OUT: register out_l and out_r, pulse out_valid, return to IDLE.
- Latency: out_valid is asserted exactly BITSIZE+6 clk after the clk edge at which the edge flop first detects the rising edge. That is 22 clk for BITSIZE = 16.
- Outputs hold their value between out_valid pulses. gain and limiting update at the SMOOTH->APPLY transition.
- Unity gain passes samples bit-exactly. enable = 0 also gives a bit-exact pass-through at the same latency.
- Boundaries:
  - peak = 0 -> target = U.
  - threshold = 0 with peak > 0 -> target = 0, output = 0.
  - threshold >= peak -> target = U.
  - Inputs and control ports are sampled only in CAPT (samples) and DIV/SMOOTH (controls); changes at any other time have no effect until the next frame.
- Reset mid-operation aborts the frame: no out_valid, all outputs take their reset values.

Test Plan:
- Reset with lrclk high, then release -> no out_valid for 2000 clk; gain = 65536, outputs 0, limiting 0.
- threshold 16384, shifts 0, in_l = 1000, in_r = -1000, lrclk edge -> out_valid 22 clk after edge detect; out_l = 1000, out_r = -1000, gain 65536.
- threshold 16384, attack 0, in_l = 32767, in_r = 0 -> gain 32769, out_l = 16383, out_r = 0, limiting 1.
- threshold 16384, attack 0, in_l = 0, in_r = -32768 -> gain 32768, out_r = -16384. Next frame with inputs 0 and release_shift 4 -> gain 32768 + 2048 = 34816.
- Gain at 32769, inputs 0, release_shift 4 -> gain 34816 after one frame; with release 0, gain 65536 after one frame; limiting 0.
- resetn low 5 clk after an edge is detected -> no out_valid that frame, gain 65536. enable = 0 with in_l = 32767, threshold 0 -> out_l = 32767.

Source files
------------

// File: rtl/stereo_limiter.sv
// Linked-gain stereo peak limiter: one gain per DACLRC frame, derived from the larger
// channel peak, smoothed with separate attack/release shifts and applied to both channels.
module stereo_limiter #(
    parameter int BITSIZE   = 16,
    parameter int SHIFTBITS = 4
) (
    input  logic                        clk,
    input  logic                        resetn,
    input  logic                        enable,
    input  logic                        lrclk,
    input  logic signed [BITSIZE-1:0]   in_l,
    input  logic signed [BITSIZE-1:0]   in_r,
    input  logic        [BITSIZE-1:0]   threshold,
    input  logic        [SHIFTBITS-1:0] attack_shift,
    input  logic        [SHIFTBITS-1:0] release_shift,
    output logic signed [BITSIZE-1:0]   out_l,
    output logic signed [BITSIZE-1:0]   out_r,
    output logic        [BITSIZE:0]     gain,
    output logic                        limiting,
    output logic                        out_valid
);
    localparam int CW = $clog2(BITSIZE + 1);
    localparam logic [BITSIZE:0] UNITY = {1'b1, {BITSIZE{1'b0}}};
    localparam logic signed [2*BITSIZE+1:0] MAXV = {{(BITSIZE+3){1'b0}}, {(BITSIZE-1){1'b1}}};
    localparam logic signed [2*BITSIZE+1:0] MINV = {{(BITSIZE+3){1'b1}}, {(BITSIZE-1){1'b0}}};

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_CAPT   = 3'd1;
    localparam logic [2:0] S_PEAK   = 3'd2;
    localparam logic [2:0] S_DIV    = 3'd3;
    localparam logic [2:0] S_SMOOTH = 3'd4;
    localparam logic [2:0] S_APPLY  = 3'd5;
    localparam logic [2:0] S_OUT    = 3'd6;

    logic                      sync1_q, sync2_q, edge_q, frame_edge;
    logic [2:0]                state_q, state_d;
    logic signed [BITSIZE-1:0] samp_l_q, samp_r_q, app_l_q, app_r_q, out_l_q, out_r_q;
    logic [BITSIZE-1:0]        abs_l_q, abs_r_q, peak_q;
    logic [BITSIZE:0]          rem_q, rem_d, rem_sh, quo_q, quo_d, gain_q, gain_d;
    logic [BITSIZE:0]          target, diff, step;
    logic                      div_ge, dec;
    logic [CW-1:0]             cnt_q;
    logic                      bypass_q, limiting_q, out_valid_q;
    logic signed [2*BITSIZE+1:0] gain_s, p_l, p_r;

    // Magnitude fits BITSIZE unsigned bits, so the most negative sample maps to 2^(BITSIZE-1).
    function automatic logic [BITSIZE-1:0] mag(input logic signed [BITSIZE-1:0] s);
        return s[BITSIZE-1] ? (~s + 1'b1) : s;
    endfunction

    function automatic logic signed [BITSIZE-1:0] sat(input logic signed [2*BITSIZE+1:0] p);
        logic signed [2*BITSIZE+1:0] v;
        v = p >>> BITSIZE;
        if (v > MAXV)      return MAXV[BITSIZE-1:0];
        else if (v < MINV) return MINV[BITSIZE-1:0];
        else               return v[BITSIZE-1:0];
    endfunction

    assign frame_edge = sync2_q & ~edge_q;

    // Restoring divide of threshold*2^BITSIZE by peak: the first step loads the threshold,
    // later steps shift in the zero low-order dividend bits.
    always_comb begin
        rem_sh = (cnt_q == '0) ? {1'b0, threshold} : (rem_q << 1);
        div_ge = rem_sh >= {1'b0, peak_q};
        rem_d  = div_ge ? rem_sh - {1'b0, peak_q} : rem_sh;
        quo_d  = {quo_q[BITSIZE-1:0], div_ge};
    end

    always_comb begin
        target = bypass_q ? UNITY : quo_q;
        dec    = target < gain_q;
        diff   = dec ? gain_q - target : target - gain_q;
        step   = diff >> (dec ? attack_shift : release_shift);
        if (diff != '0 && step == '0) step = {{BITSIZE{1'b0}}, 1'b1};
        gain_d = !enable ? UNITY : (dec ? gain_q - step : gain_q + step);
    end

    always_comb begin
        gain_s = $signed({{(BITSIZE+1){1'b0}}, gain_q});
        p_l    = samp_l_q * gain_s;
        p_r    = samp_r_q * gain_s;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (frame_edge) state_d = S_CAPT;
            S_CAPT:   state_d = S_PEAK;
            S_PEAK:   state_d = S_DIV;
            S_DIV:    if (cnt_q == CW'(BITSIZE)) state_d = S_SMOOTH;
            S_SMOOTH: state_d = S_APPLY;
            S_APPLY:  state_d = S_OUT;
            S_OUT:    state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            sync1_q     <= 1'b1;
            sync2_q     <= 1'b1;
            edge_q      <= 1'b1;
            state_q     <= S_IDLE;
            samp_l_q    <= '0;
            samp_r_q    <= '0;
            abs_l_q     <= '0;
            abs_r_q     <= '0;
            peak_q      <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            cnt_q       <= '0;
            bypass_q    <= 1'b1;
            gain_q      <= UNITY;
            limiting_q  <= 1'b0;
            app_l_q     <= '0;
            app_r_q     <= '0;
            out_l_q     <= '0;
            out_r_q     <= '0;
            out_valid_q <= 1'b0;
        end else begin
            sync1_q     <= lrclk;
            sync2_q     <= sync1_q;
            edge_q      <= sync2_q;
            state_q     <= state_d;
            out_valid_q <= 1'b0;
            case (state_q)
                S_CAPT: begin
                    samp_l_q <= in_l;
                    samp_r_q <= in_r;
                    abs_l_q  <= mag(in_l);
                    abs_r_q  <= mag(in_r);
                end
                S_PEAK: begin
                    peak_q <= (abs_l_q > abs_r_q) ? abs_l_q : abs_r_q;
                    cnt_q  <= '0;
                end
                S_DIV: begin
                    rem_q <= rem_d;
                    quo_q <= quo_d;
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == '0) bypass_q <= !(enable && (peak_q > threshold));
                end
                S_SMOOTH: begin
                    gain_q     <= gain_d;
                    limiting_q <= gain_d < UNITY;
                end
                S_APPLY: begin
                    app_l_q <= sat(p_l);
                    app_r_q <= sat(p_r);
                end
                S_OUT: begin
                    out_l_q     <= app_l_q;
                    out_r_q     <= app_r_q;
                    out_valid_q <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign out_l     = out_l_q;
    assign out_r     = out_r_q;
    assign gain      = gain_q;
    assign limiting  = limiting_q;
    assign out_valid = out_valid_q;
endmodule

// File: tb/tb_stereo_limiter.sv
// Directed bench for stereo_limiter: a frame-level arithmetic model checked every cycle,
// plus literal expectations at the end of each frame.
module tb_stereo_limiter;
    localparam int NOCHK = 99999;
    localparam int U = 65536;

    logic               clk = 1'b0, resetn = 1'b0, enable = 1'b1, lrclk = 1'b1;
    logic signed [15:0] in_l = '0, in_r = '0;
    logic        [15:0] threshold = '0;
    logic        [3:0]  atk = '0, rel = '0;
    logic signed [15:0] out_l, out_r;
    logic        [16:0] gain;
    logic               limiting, out_valid;

    stereo_limiter #(.BITSIZE(16), .SHIFTBITS(4)) dut (
        .clk(clk), .resetn(resetn), .enable(enable), .lrclk(lrclk),
        .in_l(in_l), .in_r(in_r), .threshold(threshold),
        .attack_shift(atk), .release_shift(rel),
        .out_l(out_l), .out_r(out_r), .gain(gain), .limiting(limiting), .out_valid(out_valid)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk = 0, n_fail = 0;
    bit chk_en = 1'b0;
    int m_pred = -1;
    int m_gain = U, m_gain_old = U, m_gain_new = U;
    int m_ol_old = 0, m_ol_new = 0, m_or_old = 0, m_or_new = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
        end
    endtask

    // Floor of x*g/2^16, saturated to 16-bit signed.
    function automatic int scale(input int x, input int g);
        longint p, q;
        p = longint'(x) * longint'(g);
        q = p / 65536;
        if ((p % 65536) != 0 && p < 0) q = q - 1;
        if (q > 32767) q = 32767;
        if (q < -32768) q = -32768;
        return int'(q);
    endfunction

    task automatic model_frame(input int l, input int r, input int thr, input int en,
                               input int a, input int rl);
        int al, ar, peak, tgt, s, g;
        al = (l < 0) ? -l : l;
        ar = (r < 0) ? -r : r;
        peak = (al > ar) ? al : ar;
        tgt = (en != 0 && peak > thr) ? int'((longint'(thr) * 65536) / peak) : U;
        g = m_gain;
        if (en == 0) g = U;
        else if (tgt < g) begin
            s = (g - tgt) >> a;
            if (s == 0) s = 1;
            g = g - s;
        end else if (tgt > g) begin
            s = (tgt - g) >> rl;
            if (s == 0) s = 1;
            g = g + s;
        end
        m_gain     = g;
        m_gain_new = g;
        m_ol_new   = scale(l, g);
        m_or_new   = scale(r, g);
    endtask

    task automatic model_reset();
        m_pred = -1;
        m_gain = U; m_gain_old = U; m_gain_new = U;
        m_ol_old = 0; m_ol_new = 0; m_or_old = 0; m_or_new = 0;
    endtask

    // Every cycle: out_valid only on the predicted cycle, outputs hold between frames.
    always @(negedge clk) begin
        if (chk_en) begin
            check("out_valid", out_valid, (cyc == m_pred));
            check("out_l", out_l, (m_pred >= 0 && cyc >= m_pred) ? m_ol_new : m_ol_old);
            check("out_r", out_r, (m_pred >= 0 && cyc >= m_pred) ? m_or_new : m_or_old);
            check("gain", gain, (m_pred >= 0 && cyc >= m_pred - 2) ? m_gain_new : m_gain_old);
            check("limiting", limiting,
                  ((m_pred >= 0 && cyc >= m_pred - 2) ? m_gain_new : m_gain_old) < U);
        end
    end

    task automatic start_frame(input int l, input int r, input int thr, input int en,
                               input int a, input int rl, output int t0);
        @(posedge clk); #1;
        lrclk = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        m_gain_old = m_gain_new; m_ol_old = m_ol_new; m_or_old = m_or_new;
        in_l = 16'(l); in_r = 16'(r); threshold = 16'(thr);
        enable = (en != 0); atk = 4'(a); rel = 4'(rl);
        lrclk = 1'b1;
        t0 = cyc;
    endtask

    task automatic frame(input int l, input int r, input int thr, input int en,
                         input int a, input int rl, input int el, input int er,
                         input int eg, input bit glitch);
        int t0;
        start_frame(l, r, thr, en, a, rl, t0);
        model_frame(l, r, thr, en, a, rl);
        m_pred = t0 + 25;
        if (glitch) begin
            // A second lrclk rise while busy must be ignored.
            while (cyc < t0 + 6) @(posedge clk);
            #1 lrclk = 1'b0;
            while (cyc < t0 + 10) @(posedge clk);
            #1 lrclk = 1'b1;
        end
        while (cyc < t0 + 25) @(posedge clk);
        @(negedge clk);
        if (el != NOCHK) check("lit_out_l", out_l, el);
        if (er != NOCHK) check("lit_out_r", out_r, er);
        if (eg != NOCHK) check("lit_gain", gain, eg);
        repeat (3) @(posedge clk);
    endtask

    task automatic abort_frame(input int l, input int r, input int thr);
        int t0;
        start_frame(l, r, thr, 1, 0, 0, t0);
        m_pred = -1;
        while (cyc < t0 + 7) @(posedge clk);
        #1 resetn = 1'b0;
        chk_en = 1'b0;
        model_reset();
        @(posedge clk); #1;
        chk_en = 1'b1;
        repeat (2) @(posedge clk);
        #1 resetn = 1'b1;
        repeat (40) @(posedge clk);
        @(negedge clk);
        check("abort_gain", gain, U);
        check("abort_out_l", out_l, 0);
    endtask

    initial begin
        model_reset();
        resetn = 1'b0; lrclk = 1'b1;
        repeat (5) @(posedge clk);
        #1 chk_en = 1'b1;
        resetn = 1'b1;
        repeat (2000) @(posedge clk);
        @(negedge clk);
        check("rst_gain", gain, U);
        check("rst_out_l", out_l, 0);
        check("rst_out_r", out_r, 0);
        check("rst_limiting", limiting, 0);

        //     in_l    in_r    thr    en a  r   exp_l   exp_r   exp_gain glitch
        frame(  1000,  -1000, 16384, 1, 0, 0,   1000,  -1000,   65536, 0);
        frame( 32767,      0, 16384, 1, 0, 0,  16383,      0,   32769, 0);
        check("lit_limiting_on", limiting, 1);
        frame(     0,      0, 16384, 1, 0, 4,      0,      0,   34816, 0);
        frame(     0,      0, 16384, 1, 0, 0,      0,      0,   65536, 0);
        check("lit_limiting_off", limiting, 0);
        frame(     0, -32768, 16384, 1, 0, 0,      0, -16384,   32768, 0);
        frame( 32767,      0, 16384, 1, 0, 4,  16383,      0,   32769, 0);
        frame(     0,      0, 16384, 1, 0, 0,      0,      0,   65536, 0);
        frame(-20000,  15000, 10000, 1, 2, 0, -17500,  13125,   57344, 0);
        frame(-20000,  15000, 10000, 1, 2, 0, -15625,  11718,   51200, 1);
        frame(   100,     -1,     0, 1, 0, 0,      0,      0,       0, 0);
        frame(     0,      0,     0, 1, 0, 15,     0,      0,       2, 0);
        abort_frame(30000, 30000, 100);
        frame( 32767,      0,     0, 0, 0, 0,  32767,      0,   65536, 0);
        frame(-32768,  12345,     0, 0, 3, 3, -32768,  12345,   65536, 0);
        frame(-32768,   -123, 32768, 1, 0, 0, -32768,   -123,   65536, 0);

        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
